cam_cmd_initiator: RTL and testbench

- Command-side initiator for the team's content-addressable memory: accepts write/search commands over a valid/ready interface and drives the CAM's active-low wrt/search strobes.
- Waits for the CAM's found/address_out response, or times out, then returns a single result over a valid/ready response channel.
- Sits between host logic (switch/FSM front end) and the CAM; the CAM itself is unchanged.

---
 rtl/cam_cmd_initiator.sv | 190 +++++++++++++++++++
 tb/tb_cam_cmd_initiator.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cmd_initiator.sv
// -----------------------------------------------------------------------------
// cam_cmd_initiator
//
// Command-side initiator for the content-addressable memory. Accepts one
// write or search command at a time over a valid/ready channel, drives the
// CAM's active-low write/search strobes, waits for the CAM's found flag (or a
// timeout), and hands back a single result over a valid/ready response channel.
//
// Parameters:
//   dataSize    - width of the stored/searched data word
//   addressSize - CAM address width (depth = 2**addressSize)
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   cmd_valid/ready    - command handshake
//   cmd_write          - 1 = write, 0 = search
//   cmd_data/cmd_addr  - data word / write address (address unused for search)
//   cam_wrt/cam_search - CAM strobes, active-low, never low together
//   cam_data           - CAM targetData
//   cam_adress         - CAM write address
//   cam_found          - CAM found flag
//   cam_address_out    - CAM matched address
//   rsp_valid/ready    - response handshake
//   rsp_write          - echo of the command type
//   rsp_hit            - write: 1; search: 1 = match, 0 = miss
//   rsp_addr           - written address / matched address / 0 on a miss
//
// Optional build macro CAM_CMD_STATS_EN adds saturating 8-bit hit_count and
// miss_count outputs, bumped on the response handshake of each search.
// -----------------------------------------------------------------------------
module cam_cmd_initiator #(
    parameter int dataSize    = 5,
    parameter int addressSize = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [dataSize-1:0]    cmd_data,
    input  logic [addressSize-1:0] cmd_addr,
    output logic                   cam_wrt,
    output logic                   cam_search,
    output logic [dataSize-1:0]    cam_data,
    output logic [addressSize-1:0] cam_adress,
    input  logic                   cam_found,
    input  logic [addressSize-1:0] cam_address_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic                   rsp_hit,
    output logic [addressSize-1:0] rsp_addr
`ifdef CAM_CMD_STATS_EN
    ,
    output logic [7:0]             hit_count,
    output logic [7:0]             miss_count
`endif
);

    localparam int depth = 2 ** addressSize;

    // The counter holds the number of completed search cycles. When it reads
    // depth in the current cycle, this cycle's edge takes it to depth+1 and
    // ends the search as a miss (unless found is seen on the same edge).
    localparam logic [addressSize:0] search_last = (addressSize + 1)'(depth);
    localparam logic [addressSize:0] count_one   = (addressSize + 1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SEARCH = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [addressSize:0]   count_reg;
    logic                   cmd_fire;
    logic                   rsp_fire;
    logic                   search_timeout;

    assign cmd_fire       = cmd_valid && cmd_ready;
    assign rsp_fire       = rsp_valid && rsp_ready;
    assign search_timeout = (count_reg == search_last);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    state_next = cmd_write ? WRITE : SEARCH;
                end
            end
            WRITE: begin
                state_next = RESP;
            end
            SEARCH: begin
                if (cam_found || search_timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus registered outputs. Strobes, ready and valid are
    // decoded from the next state so they line up with the state they belong
    // to, while still reading 0/1 as required during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            cmd_ready  <= 1'b0;
            cam_wrt    <= 1'b1;
            cam_search <= 1'b1;
            cam_data   <= '0;
            cam_adress <= '0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_addr   <= '0;
        end else begin
            state_reg  <= state_next;
            cmd_ready  <= (state_next == IDLE);
            cam_wrt    <= (state_next != WRITE);
            cam_search <= (state_next != SEARCH);
            rsp_valid  <= (state_next == RESP);

            case (state_reg)
                IDLE: begin
                    if (cmd_fire) begin
                        cam_data   <= cmd_data;
                        cam_adress <= cmd_addr;
                        count_reg  <= '0;
                    end
                end
                WRITE: begin
                    rsp_write <= 1'b1;
                    rsp_hit   <= 1'b1;
                    rsp_addr  <= cam_adress;
                end
                SEARCH: begin
                    count_reg <= count_reg + count_one;
                    // A found flag on the timeout edge still counts as a hit.
                    if (cam_found) begin
                        rsp_write <= 1'b0;
                        rsp_hit   <= 1'b1;
                        rsp_addr  <= cam_address_out;
                    end else if (search_timeout) begin
                        rsp_write <= 1'b0;
                        rsp_hit   <= 1'b0;
                        rsp_addr  <= '0;
                    end
                end
                default: begin
                    // RESP: response fields held stable until consumed
                end
            endcase
        end
    end

`ifdef CAM_CMD_STATS_EN
    // Saturating search statistics, counted when the host takes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 8'd0;
            miss_count <= 8'd0;
        end else if (rsp_fire && !rsp_write) begin
            if (rsp_hit) begin
                if (hit_count != 8'hFF) begin
                    hit_count <= hit_count + 8'd1;
                end
            end else begin
                if (miss_count != 8'hFF) begin
                    miss_count <= miss_count + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_cmd_initiator.sv
// -----------------------------------------------------------------------------
// tb_cam_cmd_initiator
//
// Directed bench for cam_cmd_initiator. Contains a small behavioural CAM:
// writes land on the edge where cam_wrt is low; while cam_search is low it
// compares one entry per edge starting at index 0 and raises found (with the
// matching index) on the edge that compares a valid matching entry. Raising
// cam_search clears the pointer and found flag.
// -----------------------------------------------------------------------------
module tb_cam_cmd_initiator;

    localparam int DW = 5;
    localparam int AW = 5;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] cmd_addr;
    logic          cam_wrt;
    logic          cam_search;
    logic [DW-1:0] cam_data;
    logic [AW-1:0] cam_adress;
    logic          cam_found;
    logic [AW-1:0] cam_address_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic          rsp_hit;
    logic [AW-1:0] rsp_addr;
`ifdef CAM_CMD_STATS_EN
    logic [7:0]    hit_count;
    logic [7:0]    miss_count;
`endif

    int tests_run;
    int tests_failed;
    int overlap_count;

    cam_cmd_initiator #(.dataSize(DW), .addressSize(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_data        (cmd_data),
        .cmd_addr        (cmd_addr),
        .cam_wrt         (cam_wrt),
        .cam_search      (cam_search),
        .cam_data        (cam_data),
        .cam_adress      (cam_adress),
        .cam_found       (cam_found),
        .cam_address_out (cam_address_out),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_write       (rsp_write),
        .rsp_hit         (rsp_hit),
        .rsp_addr        (rsp_addr)
`ifdef CAM_CMD_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural CAM ----------------
    logic [DW-1:0] cam_mem [DEPTH];
    logic          cam_vld [DEPTH];
    logic [AW:0]   cam_ptr;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            cam_mem[i] = '0;
            cam_vld[i] = 1'b0;
        end
        cam_ptr         = '0;
        cam_found       = 1'b0;
        cam_address_out = '0;
    end

    always @(posedge clk) begin
        if (!cam_wrt) begin
            cam_mem[cam_adress] <= cam_data;
            cam_vld[cam_adress] <= 1'b1;
        end
        if (cam_search) begin
            cam_ptr         <= '0;
            cam_found       <= 1'b0;
            cam_address_out <= '0;
        end else if (!cam_found && cam_ptr < (AW + 1)'(DEPTH)) begin
            if (cam_vld[cam_ptr[AW-1:0]] && cam_mem[cam_ptr[AW-1:0]] == cam_data) begin
                cam_found       <= 1'b1;
                cam_address_out <= cam_ptr[AW-1:0];
            end else begin
                cam_ptr <= cam_ptr + 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (!cam_wrt && !cam_search) overlap_count++;
    endtask

    // Issue one command with rsp_ready held high and report what came back.
    // lat is the cycle index (1 = first cycle after the accept edge) in which
    // rsp_valid was first seen; 0 means it never arrived.
    task automatic run_cmd(input logic w, input logic [DW-1:0] d, input logic [AW-1:0] a,
                           output int low_s, output int low_w, output int lat,
                           output logic hit, output logic [AW-1:0] ra, output logic rw);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        tests_run++;
        if (!cmd_ready) begin
            tests_failed++;
            $display("[TB] FAIL cmd_ready_wait: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_data  = d;
        cmd_addr  = a;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        low_s = 0;
        low_w = 0;
        lat   = 0;
        hit   = 1'b0;
        ra    = '0;
        rw    = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (!cam_search) low_s++;
            if (!cam_wrt) low_w++;
            if (rsp_valid) begin
                lat = c;
                hit = rsp_hit;
                ra  = rsp_addr;
                rw  = rsp_write;
                break;
            end
            tick();
        end
        tests_run++;
        if (lat == 0) begin
            tests_failed++;
            $display("[TB] FAIL rsp_timeout: rsp_valid never seen within 100 cycles (w=%0b d=%0d)", w, d);
        end
        tick();
        rsp_ready = 1'b0;
        $display("[TB] cmd w=%0b data=%0d addr=%0d -> lat=%0d search_low=%0d wrt_low=%0d rsp_write=%0b hit=%0b rsp_addr=%0d",
                 w, d, a, lat, low_s, low_w, rw, hit, ra);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (cmd_ready !== 1'b0 || cam_wrt !== 1'b1 || cam_search !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: ready=%0b wrt=%0b search=%0b valid=%0b required 0 1 1 0",
                     cmd_ready, cam_wrt, cam_search, rsp_valid);
        end
        tests_run++;
        if (cam_data !== '0 || cam_adress !== '0 || rsp_write !== 1'b0 || rsp_hit !== 1'b0 || rsp_addr !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: data=%0d adr=%0d rw=%0b hit=%0b ra=%0d required all 0",
                     cam_data, cam_adress, rsp_write, rsp_hit, rsp_addr);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_ready: cmd_ready=%0b required 1", cmd_ready);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_write();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_data  = 5'd7;
        cmd_addr  = 5'd3;
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if (cam_wrt !== 1'b0 || cam_search !== 1'b1 || cam_adress !== 5'd3 || cam_data !== 5'd7 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL write_strobe: wrt=%0b search=%0b adr=%0d data=%0d ready=%0b required 0 1 3 7 0",
                     cam_wrt, cam_search, cam_adress, cam_data, cmd_ready);
        end
        tick();
        tests_run++;
        if (cam_wrt !== 1'b1 || rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_hit !== 1'b1 || rsp_addr !== 5'd3 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL write_rsp: wrt=%0b valid=%0b rw=%0b hit=%0b ra=%0d ready=%0b required 1 1 1 1 3 0",
                     cam_wrt, rsp_valid, rsp_write, rsp_hit, rsp_addr, cmd_ready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL write_done: valid=%0b ready=%0b required 0 1", rsp_valid, cmd_ready);
        end
        $display("[TB] write addr=3 data=7 checked");
    endtask

    task automatic test_search_hit();
        int ls, lw, lat;
        logic hit, rw;
        logic [AW-1:0] ra;
        run_cmd(1'b1, 5'd21, 5'd12, ls, lw, lat, hit, ra, rw);
        tests_run++;
        if (lat !== 2 || lw !== 1 || ls !== 0 || rw !== 1'b1 || hit !== 1'b1 || ra !== 5'd12) begin
            tests_failed++;
            $display("[TB] FAIL write12: lat=%0d wlow=%0d slow=%0d rw=%0b hit=%0b ra=%0d required 2 1 0 1 1 12",
                     lat, lw, ls, rw, hit, ra);
        end
        run_cmd(1'b0, 5'd21, 5'd0, ls, lw, lat, hit, ra, rw);
        tests_run++;
        if (ls !== 14 || lw !== 0 || lat !== 15 || rw !== 1'b0 || hit !== 1'b1 || ra !== 5'd12) begin
            tests_failed++;
            $display("[TB] FAIL search21: slow=%0d wlow=%0d lat=%0d rw=%0b hit=%0b ra=%0d required 14 0 15 0 1 12",
                     ls, lw, lat, rw, hit, ra);
        end
        // Entry written earlier at index 3
        run_cmd(1'b0, 5'd7, 5'd0, ls, lw, lat, hit, ra, rw);
        tests_run++;
        if (ls !== 5 || lat !== 6 || hit !== 1'b1 || ra !== 5'd3) begin
            tests_failed++;
            $display("[TB] FAIL search7: slow=%0d lat=%0d hit=%0b ra=%0d required 5 6 1 3", ls, lat, hit, ra);
        end
    endtask

    task automatic test_search_miss();
        int ls, lw, lat;
        logic hit, rw;
        logic [AW-1:0] ra;
        run_cmd(1'b0, 5'd9, 5'd0, ls, lw, lat, hit, ra, rw);
        tests_run++;
        if (ls !== 33 || lw !== 0 || rw !== 1'b0 || hit !== 1'b0 || ra !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL search_miss: slow=%0d wlow=%0d rw=%0b hit=%0b ra=%0d required 33 0 0 0 0",
                     ls, lw, rw, hit, ra);
        end
    endtask

    task automatic test_index_edges();
        int ls, lw, lat;
        logic hit, rw;
        logic [AW-1:0] ra;
        // Index 0: first compared entry
        run_cmd(1'b1, 5'd5, 5'd0, ls, lw, lat, hit, ra, rw);
        run_cmd(1'b0, 5'd5, 5'd0, ls, lw, lat, hit, ra, rw);
        tests_run++;
        if (ls !== 2 || lat !== 3 || hit !== 1'b1 || ra !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL search_idx0: slow=%0d lat=%0d hit=%0b ra=%0d required 2 3 1 0", ls, lat, hit, ra);
        end
        // Index 31: found arrives on the same edge as the timeout, hit wins
        run_cmd(1'b1, 5'd30, 5'd31, ls, lw, lat, hit, ra, rw);
        run_cmd(1'b0, 5'd30, 5'd0, ls, lw, lat, hit, ra, rw);
        tests_run++;
        if (ls !== 33 || lat !== 34 || hit !== 1'b1 || ra !== 5'd31) begin
            tests_failed++;
            $display("[TB] FAIL search_idx31: slow=%0d lat=%0d hit=%0b ra=%0d required 33 34 1 31", ls, lat, hit, ra);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        int bad_fields, bad_ctrl;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_data  = 5'd21;
        cmd_addr  = 5'd0;
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 100) begin
            tick();
            guard++;
        end
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_wait: rsp_valid=%0b required 1", rsp_valid);
        end
        bad_fields = 0;
        bad_ctrl   = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_hit !== 1'b1 || rsp_addr !== 5'd12) bad_fields++;
            if (cam_wrt !== 1'b1 || cam_search !== 1'b1 || cmd_ready !== 1'b0) bad_ctrl++;
            // Offer a write to address 20 mid-stall; it must be ignored
            cmd_valid = (c == 2);
            cmd_write = 1'b1;
            cmd_data  = 5'd1;
            cmd_addr  = 5'd20;
            tick();
        end
        cmd_valid = 1'b0;
        tests_run++;
        if (bad_fields !== 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_fields: %0d unstable cycles required 0", bad_fields);
        end
        tests_run++;
        if (bad_ctrl !== 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_ctrl: %0d bad strobe/ready cycles required 0", bad_ctrl);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cam_vld[20] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: valid=%0b ready=%0b entry20=%0b required 0 1 0",
                     rsp_valid, cmd_ready, cam_vld[20]);
        end
        $display("[TB] backpressure 5 cycles checked");
    endtask

    task automatic test_reset_mid_search();
        int ls, lw, lat;
        logic hit, rw;
        logic [AW-1:0] ra;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_data  = 5'd21;
        cmd_addr  = 5'd0;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        tests_run++;
        if (cam_search !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_pre: cam_search=%0b required 0", cam_search);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (cam_search !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || cam_wrt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst: search=%0b valid=%0b ready=%0b wrt=%0b required 1 0 0 1",
                     cam_search, rsp_valid, cmd_ready, cam_wrt);
        end
        rst = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_idle: cmd_ready=%0b required 1", cmd_ready);
        end
        run_cmd(1'b0, 5'd21, 5'd0, ls, lw, lat, hit, ra, rw);
        tests_run++;
        if (hit !== 1'b1 || ra !== 5'd12 || lat !== 15) begin
            tests_failed++;
            $display("[TB] FAIL midrst_search: hit=%0b ra=%0d lat=%0d required 1 12 15", hit, ra, lat);
        end
    endtask

`ifdef CAM_CMD_STATS_EN
    task automatic test_stats();
        int ls, lw, lat;
        logic hit, rw;
        logic [AW-1:0] ra;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (hit_count !== 8'd0 || miss_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL stats_reset: hit=%0d miss=%0d required 0 0", hit_count, miss_count);
        end
        run_cmd(1'b0, 5'd21, 5'd0, ls, lw, lat, hit, ra, rw);
        run_cmd(1'b0, 5'd7, 5'd0, ls, lw, lat, hit, ra, rw);
        run_cmd(1'b0, 5'd9, 5'd0, ls, lw, lat, hit, ra, rw);
        tests_run++;
        if (hit_count !== 8'd2 || miss_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL stats_mix: hit=%0d miss=%0d required 2 1", hit_count, miss_count);
        end
        for (int i = 0; i < 300; i++) begin
            run_cmd(1'b0, 5'd9, 5'd0, ls, lw, lat, hit, ra, rw);
        end
        tests_run++;
        if (miss_count !== 8'd255 || hit_count !== 8'd2) begin
            tests_failed++;
            $display("[TB] FAIL stats_sat: hit=%0d miss=%0d required 2 255", hit_count, miss_count);
        end
    endtask
`endif

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        overlap_count = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_data  = '0;
        cmd_addr  = '0;
        rsp_ready = 1'b0;

        test_reset();
        test_write();
        test_search_hit();
        test_search_miss();
        test_index_edges();
        test_backpressure();
        test_reset_mid_search();
`ifdef CAM_CMD_STATS_EN
        test_stats();
`endif
        tests_run++;
        if (overlap_count !== 0) begin
            tests_failed++;
            $display("[TB] FAIL strobe_overlap: %0d cycles with both strobes low, required 0", overlap_count);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
